cpu_exec_stage: RTL

- Execute/writeback stage directly downstream of the registered instruction decoder in the 4-bit CPU.
- Owns the program counter, registers A, B and OUT, and the carry flag.
- Runs a two-phase FETCH/EXEC sequencer: presents the PC to the program ROM, forwards the opcode to the decoder, and applies the decoder's 6-bit control word one cycle later.

---
 rtl/cpu_exec_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cpu_exec_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cpu_exec_stage                                                |
// | Purpose  : Execute/writeback stage of the 4-bit CPU. Holds PC, A, B,     |
// |            OUT and CARRY and runs a two-phase FETCH/EXEC sequencer. The  |
// |            opcode goes to an external registered decoder during FETCH;   |
// |            its 6-bit control word is applied during EXEC.                |
// | Ports    : clk_i       - clock, rising edge                             |
// |            rst_ni      - asynchronous active-low reset                   |
// |            run_i       - sequencer advances when 1 (sampled in FETCH)    |
// |            pc_addr_o   - program ROM address (PC register)               |
// |            rom_data_i  - ROM word {opcode, imm}                          |
// |            order_o     - opcode forwarded to the decoder                 |
// |            decoded_i   - {src_sel[1:0], nload_a, nload_b, nload_out,     |
// |                           nload_pc}                                      |
// |            in_port_i   - external input port                             |
// |            out_port_o  - OUT register                                    |
// |            carry_o     - carry flag                                      |
// |            illegal_o   - one-cycle pulse after an undefined instruction  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cpu_exec_stage #(
  parameter int DATA_W   = 4,
  parameter int PC_W     = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run_i,
  output logic [PC_W-1:0]   pc_addr_o,
  input  logic [7:0]        rom_data_i,
  output logic [3:0]        order_o,
  input  logic [5:0]        decoded_i,
  input  logic [DATA_W-1:0] in_port_i,
  output logic [DATA_W-1:0] out_port_o,
  output logic              carry_o,
  output logic              illegal_o
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_EXEC  = 1'b1;

  localparam logic [3:0] OP_JNC  = 4'hE;

  logic [0:0]        state_q,   state_d;
  logic [PC_W-1:0]   pc_q,      pc_d;
  logic [DATA_W-1:0] a_q,       a_d;
  logic [DATA_W-1:0] b_q,       b_d;
  logic [DATA_W-1:0] out_q,     out_d;
  logic              carry_q,   carry_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic              jnc_q,     jnc_d;

  logic [DATA_W-1:0] w_src;
  logic [DATA_W:0]   w_sum;
  logic              w_illegal;
  logic              w_take_jump;

  // Decoder registers this on the FETCH edge, so it is a straight wire.
  assign order_o = rom_data_i[7:4];

  always_comb begin
    w_src = '0;
    case (decoded_i[5:4])
      2'b00:   w_src = a_q;
      2'b01:   w_src = b_q;
      2'b10:   w_src = in_port_i;
      default: w_src = '0;
    endcase
  end

  // One extra bit so the carry-out drops out of the same adder.
  assign w_sum = {1'b0, w_src} + {1'b0, imm_q};

  // An all-zero load field is the decoder's fallback word for unknown opcodes.
  assign w_illegal = (decoded_i[3:0] == 4'b0000);

  // JNC is blocked by the carry produced by the previous instruction,
  // i.e. the flag value before this EXEC edge rewrites it.
  assign w_take_jump = !decoded_i[0] && (!jnc_q || !carry_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    b_d       = b_q;
    out_d     = out_q;
    carry_d   = carry_q;
    illegal_d = 1'b0;
    imm_d     = imm_q;
    jnc_d     = jnc_q;

    case (state_q)
      S_FETCH: begin
        if (run_i) begin
          state_d = S_EXEC;
          imm_d   = DATA_W'(rom_data_i[3:0]);
          jnc_d   = (rom_data_i[7:4] == OP_JNC);
        end
      end
      default: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PC_W'(1);
        if (w_illegal) begin
          illegal_d = 1'b1;
        end else begin
          if (!decoded_i[3]) a_d   = w_sum[DATA_W-1:0];
          if (!decoded_i[2]) b_d   = w_sum[DATA_W-1:0];
          if (!decoded_i[1]) out_d = w_sum[DATA_W-1:0];
          carry_d = w_sum[DATA_W];
          if (w_take_jump) pc_d = PC_W'(imm_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_W'(RESET_PC);
      a_q       <= '0;
      b_q       <= '0;
      out_q     <= '0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
      imm_q     <= '0;
      jnc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      out_q     <= out_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
      imm_q     <= imm_d;
      jnc_q     <= jnc_d;
    end
  end

  assign pc_addr_o  = pc_q;
  assign out_port_o = out_q;
  assign carry_o    = carry_q;
  assign illegal_o  = illegal_q;

endmodule
`default_nettype wire
